// File: rtl/message_passer.sv
`default_nettype none
// ============================================================================
// message_passer : systolic-array PE datapath with ready/ack command handshake
// Optional feature macro: MAC_SATURATE_EN (saturating accumulator on MAC)
// Revision: 1.0
// ============================================================================
module message_passer #(
  parameter int PRECISION        = 8,
  parameter int OUTPUT_PRECISION = 32
) (
  input  logic                        CLK,
  input  logic                        rst_n,
  input  logic                        ack,
  output logic                        ready,
  input  logic [2:0]                  command_to_execute,
  input  logic                        image_to_shift,
  input  logic [1:0]                  shift_direction,
  input  logic [PRECISION-1:0]        isu,
  input  logic [PRECISION-1:0]        isd,
  input  logic [PRECISION-1:0]        isl,
  input  logic [PRECISION-1:0]        isr,
  output logic [PRECISION-1:0]        osu,
  output logic [PRECISION-1:0]        osd,
  output logic [PRECISION-1:0]        osl,
  output logic [PRECISION-1:0]        osr,
  output logic [PRECISION-1:0]        A,
  output logic [PRECISION-1:0]        B,
  output logic [OUTPUT_PRECISION-1:0] s_out,
  input  logic [PRECISION-1:0]        a_overwrite,
  input  logic [PRECISION-1:0]        b_overwrite,
  input  logic [OUTPUT_PRECISION-1:0] s_out_overwrite
);

  localparam logic [2:0] OP_MAC   = 3'd0;
  localparam logic [2:0] OP_UP    = 3'd1;
  localparam logic [2:0] OP_DOWN  = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_RIGHT = 3'd4;
  localparam logic [2:0] OP_LDAB  = 3'd5;
  localparam logic [2:0] OP_LDS   = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic                        execute;
  logic [2*PRECISION-1:0]      product;
  logic [OUTPUT_PRECISION:0]   mac_sum;
  logic [OUTPUT_PRECISION-1:0] mac_result;
  logic [PRECISION-1:0]        shift_src;
  logic                        unused_inputs;

  logic [PRECISION-1:0]        a_nx, b_nx, osu_nx, osd_nx, osl_nx, osr_nx;
  logic [OUTPUT_PRECISION-1:0] s_nx;

  assign execute   = (state == IDLE) && !ack;
  assign ready     = (state == DONE);
  assign shift_src = image_to_shift ? B : A;

  assign product = {{PRECISION{1'b0}}, A} * {{PRECISION{1'b0}}, B};
  assign mac_sum = {1'b0, s_out} + (OUTPUT_PRECISION+1)'(product);

`ifdef MAC_SATURATE_EN
  // Carry out of the accumulate means the true sum exceeded full scale.
  assign mac_result    = mac_sum[OUTPUT_PRECISION] ? '1 : mac_sum[OUTPUT_PRECISION-1:0];
  assign unused_inputs = &{1'b0, shift_direction};
`else
  assign mac_result    = mac_sum[OUTPUT_PRECISION-1:0];
  assign unused_inputs = &{1'b0, shift_direction, mac_sum[OUTPUT_PRECISION]};
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!ack) state_nx = DONE;
      DONE:    if (ack)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    a_nx   = A;
    b_nx   = B;
    s_nx   = s_out;
    osu_nx = osu;
    osd_nx = osd;
    osl_nx = osl;
    osr_nx = osr;
    if (execute) begin
      case (command_to_execute)
        OP_MAC: s_nx = mac_result;
        OP_UP: begin
          if (image_to_shift) b_nx = isu; else a_nx = isu;
          osu_nx = shift_src;
        end
        OP_DOWN: begin
          if (image_to_shift) b_nx = isd; else a_nx = isd;
          osd_nx = shift_src;
        end
        OP_LEFT: begin
          if (image_to_shift) b_nx = isl; else a_nx = isl;
          osl_nx = shift_src;
        end
        OP_RIGHT: begin
          if (image_to_shift) b_nx = isr; else a_nx = isr;
          osr_nx = shift_src;
        end
        OP_LDAB: begin
          a_nx = a_overwrite;
          b_nx = b_overwrite;
        end
        OP_LDS: s_nx = s_out_overwrite;
        OP_CLEAR: begin
          a_nx   = '0;
          b_nx   = '0;
          s_nx   = '0;
          osu_nx = '0;
          osd_nx = '0;
          osl_nx = '0;
          osr_nx = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      A     <= '0;
      B     <= '0;
      s_out <= '0;
      osu   <= '0;
      osd   <= '0;
      osl   <= '0;
      osr   <= '0;
    end else begin
      A     <= a_nx;
      B     <= b_nx;
      s_out <= s_nx;
      osu   <= osu_nx;
      osd   <= osd_nx;
      osl   <= osl_nx;
      osr   <= osr_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_message_passer.sv
`default_nettype none
// ============================================================================
// tb_message_passer : directed bench with a per-cycle reference model
// Revision: 1.0
// ============================================================================
module tb_message_passer;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        ack;
  logic        ready;
  logic [2:0]  command_to_execute;
  logic        image_to_shift;
  logic [1:0]  shift_direction;
  logic [7:0]  isu, isd, isl, isr;
  logic [7:0]  osu, osd, osl, osr;
  logic [7:0]  A, B;
  logic [31:0] s_out;
  logic [7:0]  a_overwrite, b_overwrite;
  logic [31:0] s_out_overwrite;

  int n_checks = 0;
  int n_fail   = 0;

  message_passer #(.PRECISION(8), .OUTPUT_PRECISION(32)) dut (
    .CLK(CLK), .rst_n(rst_n), .ack(ack), .ready(ready),
    .command_to_execute(command_to_execute), .image_to_shift(image_to_shift),
    .shift_direction(shift_direction),
    .isu(isu), .isd(isd), .isl(isl), .isr(isr),
    .osu(osu), .osd(osd), .osl(osl), .osr(osr),
    .A(A), .B(B), .s_out(s_out),
    .a_overwrite(a_overwrite), .b_overwrite(b_overwrite),
    .s_out_overwrite(s_out_overwrite)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the operand/accumulator/port state as plain variables.
  logic [7:0]  m_a, m_b;
  logic [31:0] m_s;
  logic [7:0]  m_os [4];
  bit          m_ready;

  function automatic void model_exec();
    logic [7:0]  ins [4];
    logic [63:0] t;
    logic [7:0]  old;
    int          d;
    ins = '{isu, isd, isl, isr};
    case (command_to_execute)
      3'd0: begin
        t = 64'(m_s) + 64'(m_a) * 64'(m_b);
`ifdef MAC_SATURATE_EN
        if (t > 64'hFFFF_FFFF) t = 64'hFFFF_FFFF;
`endif
        m_s = t[31:0];
      end
      3'd1, 3'd2, 3'd3, 3'd4: begin
        d   = int'(command_to_execute) - 1;
        old = image_to_shift ? m_b : m_a;
        if (image_to_shift) m_b = ins[d]; else m_a = ins[d];
        m_os[d] = old;
      end
      3'd5: begin m_a = a_overwrite; m_b = b_overwrite; end
      3'd6: m_s = s_out_overwrite;
      default: begin
        m_a = 0; m_b = 0; m_s = 0;
        foreach (m_os[k]) m_os[k] = 0;
      end
    endcase
  endfunction

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_s = 0; m_ready = 0;
      foreach (m_os[k]) m_os[k] = 0;
    end else if (m_ready) begin
      if (ack) m_ready = 0;
    end else if (!ack) begin
      model_exec();
      m_ready = 1;
    end
  end

  always @(negedge CLK) begin
    if (rst_n === 1'b1) begin
      chk("cyc_ready", 32'(ready), 32'(m_ready));
      chk("cyc_A",     32'(A),     32'(m_a));
      chk("cyc_B",     32'(B),     32'(m_b));
      chk("cyc_s_out", s_out,      m_s);
      chk("cyc_osu",   32'(osu),   32'(m_os[0]));
      chk("cyc_osd",   32'(osd),   32'(m_os[1]));
      chk("cyc_osl",   32'(osl),   32'(m_os[2]));
      chk("cyc_osr",   32'(osr),   32'(m_os[3]));
    end
  end

  task automatic issue(input logic [2:0] cmd, input logic img);
    bit got;
    @(negedge CLK);
    command_to_execute = cmd;
    image_to_shift     = img;
    ack                = 1'b0;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge CLK);
      if (ready) got = 1;
    end
    chk("ready_rise_timeout", 32'(got), 32'd1);
  endtask

  task automatic release_ack();
    bit got;
    ack = 1'b1;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge CLK);
      if (!ready) got = 1;
    end
    chk("ready_fall_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; ack = 1'b1; command_to_execute = 3'd0; image_to_shift = 1'b0;
    shift_direction = 2'd0; isu = 0; isd = 0; isl = 0; isr = 0;
    a_overwrite = 0; b_overwrite = 0; s_out_overwrite = 0;
    repeat (3) @(negedge CLK);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_A", 32'(A), 0);
    chk("rst_s_out", s_out, 0);
    rst_n = 1'b1;

    isu = 8'h69; issue(3'd1, 1'b0);
    chk("up_A", 32'(A), 32'h69);
    chk("up_osu", 32'(osu), 32'h00);
    release_ack();

    isd = 8'h07; issue(3'd2, 1'b0);
    chk("down_A", 32'(A), 32'h07);
    chk("down_osd", 32'(osd), 32'h69);
    release_ack();

    isl = 8'h86; issue(3'd3, 1'b1);
    chk("left_B", 32'(B), 32'h86);
    chk("left_osl", 32'(osl), 32'h00);
    chk("left_A_kept", 32'(A), 32'h07);
    release_ack();

    isr = 8'hA6; issue(3'd4, 1'b1);
    chk("right_B", 32'(B), 32'hA6);
    chk("right_osr", 32'(osr), 32'h86);
    release_ack();

    issue(3'd0, 1'b0);
    chk("mac1", s_out, 32'd1162);
    release_ack();
    issue(3'd0, 1'b0);
    chk("mac2", s_out, 32'd2324);
    release_ack();

    a_overwrite = 8'h3D; b_overwrite = 8'h71; issue(3'd5, 1'b0);
    chk("ldab_A", 32'(A), 32'h3D);
    chk("ldab_B", 32'(B), 32'h71);
    release_ack();
    s_out_overwrite = 32'h5DF6_4944; issue(3'd6, 1'b0);
    chk("lds", s_out, 32'h5DF6_4944);
    release_ack();

    s_out_overwrite = 32'hFFFF_FFFF; issue(3'd6, 1'b0); release_ack();
    a_overwrite = 8'hFF; b_overwrite = 8'hFF; issue(3'd5, 1'b0); release_ack();
    issue(3'd0, 1'b0);
`ifdef MAC_SATURATE_EN
    chk("mac_sat", s_out, 32'hFFFF_FFFF);
`else
    chk("mac_wrap", s_out, 32'h0000_FE00);
`endif
    release_ack();

    issue(3'd7, 1'b0);
    chk("clr_A", 32'(A), 0);
    chk("clr_B", 32'(B), 0);
    chk("clr_s", s_out, 0);
    chk("clr_os", {osu, osd, osl, osr}, 0);
    release_ack();

    a_overwrite = 8'd3; b_overwrite = 8'd5; issue(3'd5, 1'b0); release_ack();
    issue(3'd0, 1'b0);
    repeat (5) @(negedge CLK);
    chk("hold_single_exec", s_out, 32'd15);
    chk("hold_ready", 32'(ready), 1);
    release_ack();

    // ack held high in IDLE: the presented opcode must not execute.
    a_overwrite = 8'hAA; command_to_execute = 3'd5;
    repeat (3) @(negedge CLK);
    chk("ack_high_ignored", 32'(A), 32'd3);
    chk("ack_high_idle", 32'(ready), 0);

    @(negedge CLK);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_A", 32'(A), 0);
    chk("async_rst_B", 32'(B), 0);
    chk("async_rst_s", s_out, 0);
    chk("async_rst_ready", 32'(ready), 0);
    @(negedge CLK);
    rst_n = 1'b1;
    repeat (2) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/message_passer.md
Name: message_passer

Overview:
- Processing element (PE) datapath and message-passing node for a 2-D systolic multiply-accumulate array.
- Holds two operand registers, A (image 0) and B (image 1), and one accumulator, s_out.
- Executes one 3-bit command per ready/ack handshake: shift an operand in from a neighbour and out to the opposite port, multiply-accumulate, overwrite registers, or clear.

Parameters:
- PRECISION, 8: width of A, B, all neighbour stream ports and a_overwrite/b_overwrite.
- OUTPUT_PRECISION, 32: width of s_out and s_out_overwrite.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ack  in  1  controller acknowledge; 1 = result consumed, 0 = command valid.
- ready  out  1  1 = command completed, outputs valid.
- command_to_execute  in  3  opcode.
- image_to_shift  in  1  shift target: 0 = A, 1 = B.
- shift_direction  in  2  reserved; ignored by the core.
- isu, isd, isl, isr  in  PRECISION  inbound streams from the up/down/left/right neighbours.
- osu, osd, osl, osr  out  PRECISION  registered outbound streams to the up/down/left/right neighbours.
- A, B  out  PRECISION  current operand registers.
- s_out  out  OUTPUT_PRECISION  accumulator.
- a_overwrite, b_overwrite  in  PRECISION  direct load values for A and B.
- s_out_overwrite  in  OUTPUT_PRECISION  direct load value for s_out.

Behaviour:
- Reset (rst_n = 0, asynchronous, any time including mid-command):
  - A, B, s_out, osu, osd, osl, osr all cleared to 0.
  - ready = 0; FSM forced to IDLE.
  - Any in-flight command is abandoned.
- FSM has two states:
  - IDLE (ready = 0): on a rising edge with ack = 0, sample command_to_execute, image_to_shift and all data inputs; execute the command in that same edge; go to DONE. With ack = 1, stay in IDLE.
  - DONE (ready = 1): hold all registers. A rising edge with ack = 1 goes to IDLE. With ack = 0, stay in DONE; no re-execution.
- Latency: results and ready = 1 are visible one cycle after the issuing edge. Exactly one execution per handshake.
- Opcodes:
  - 000 MAC: s_out <= s_out + A*B. The multiply is unsigned, 2*PRECISION bits, zero-extended, and the sum wraps modulo 2^OUTPUT_PRECISION.
  - 001 shift up: X <= isu; osu <= old X.
  - 010 shift down: X <= isd; osd <= old X.
  - 011 shift left: X <= isl; osl <= old X.
  - 100 shift right: X <= isr; osr <= old X.
  - 101: A <= a_overwrite; B <= b_overwrite.
  - 110: s_out <= s_out_overwrite.
  - 111 clear: A, B, s_out and all os* outputs <= 0.
- In the shift opcodes, X is A when image_to_shift = 0 and B when it is 1.
- Only the addressed os* port and the selected operand change on a shift. The other operand, the other os* ports and s_out keep their values.
- Outputs not named by an opcode hold their value.
- Simultaneous ack = 1 and a new opcode in IDLE: the opcode is ignored.

Optional Feature:
- Macro MAC_SATURATE_EN.
- Defined: opcode 000 saturates s_out at 2^OUTPUT_PRECISION-1 instead of wrapping; the carry out of the accumulator add selects all-ones.
- Undefined: the accumulator wraps modulo 2^OUTPUT_PRECISION.
- No other behaviour differs.

Test Plan:
- After reset, ack = 0, cmd 001, image 0, isu = 0x69 -> ready = 1 next cycle; A = 0x69, osu = 0x00.
- ack = 1 until ready = 0, then ack = 0, cmd 010, image 0, isd = 0x07 -> A = 0x07, osd = 0x69. Follow with cmd 011, image 1, isl = 0x86 -> B = 0x86, osl = 0x00. Follow with cmd 100, image 1, isr = 0xA6 -> B = 0xA6, osr = 0x86.
- With A = 7, B = 166, s_out = 0: cmd 000 -> s_out = 1162 (0x48A). Repeat -> 2324.
- cmd 101 with a_overwrite = 0x3D, b_overwrite = 0x71 -> A = 0x3D, B = 0x71. Then cmd 110 with s_out_overwrite = 0x5DF64944 -> s_out = 0x5DF64944.
- Wrap/saturate: s_out = 0xFFFFFFFF, A = B = 0xFF, cmd 000 -> s_out = 0x0000FE00 (wrap), or 0xFFFFFFFF with MAC_SATURATE_EN. Then cmd 111 -> A = B = s_out = 0, all os* = 0.
- Handshake/reset: holding ack = 0 in DONE for 5 cycles -> single execution only. Asserting rst_n = 0 mid-IDLE between edges -> all outputs 0 and ready = 0 immediately, without waiting for a clock edge.
